// File: rtl/pedometer_cmd_seq.sv
// pedometer_cmd_seq
// -----------------
// Upstream command sequencer for the pedometer core. Two small FIFOs hold
// accelerometer sample pairs and weight-register writes. A small FSM picks the
// next command and drives the core's one-cycle command interface:
//   countSteps        with A/B
//   updateWeight      with Addr1/Data1
//   dualUpdateWeights with Addr1/Data1 and Addr2/Data2
// After every command it holds an idle gap of CMD_GAP cycles.
//
// Ports
//   clk, reset                  rising-edge clock, async active-low reset
//   sample_valid/_a/_b/_ready   sample-pair push handshake
//   wr_valid/_addr/_data/_ready weight-write push handshake
//   countSteps, updateWeight,
//   dualUpdateWeights           one-cycle command pulses, mutually exclusive
//   A, B, Addr1, Data1,
//   Addr2, Data2                command fields, held until the next command
//                               of the same kind overwrites them
//   busy                        any FIFO non-empty or FSM not idle
module pedometer_cmd_seq #(
   parameter int SAMPLE_DEPTH = 4,
   parameter int WR_DEPTH     = 4,
   parameter int CMD_GAP      = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_valid,
   input  logic [7:0] sample_a,
   input  logic [7:0] sample_b,
   output logic       sample_ready,
   input  logic       wr_valid,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       countSteps,
   output logic       updateWeight,
   output logic       dualUpdateWeights,
   output logic [7:0] A,
   output logic [7:0] B,
   output logic [2:0] Addr1,
   output logic [7:0] Data1,
   output logic [2:0] Addr2,
   output logic [7:0] Data2,
   output logic       busy
);

   localparam int SPW = $clog2(SAMPLE_DEPTH);
   localparam int WPW = $clog2(WR_DEPTH);
   localparam logic [SPW:0] S_FULL   = (SPW + 1)'(SAMPLE_DEPTH);
   localparam logic [WPW:0] W_FULL   = (WPW + 1)'(WR_DEPTH);
   localparam logic [3:0]   GAP_LOAD = (CMD_GAP > 0) ? 4'(CMD_GAP - 1) : 4'd0;

   typedef enum logic [2:0] {IDLE, ISSUE_STEP, ISSUE_SINGLE, ISSUE_DUAL, GAP} state_t;
   typedef enum logic [1:0] {PICK_NONE, PICK_STEP, PICK_SINGLE, PICK_DUAL} pick_t;

   state_t     state;
   pick_t      pick;
   logic [3:0] gap_cnt;
   logic       armed;        // set by the first clock edge after reset release

   // ---------------- sample FIFO ----------------
   logic [7:0]     s_mem_a [SAMPLE_DEPTH];
   logic [7:0]     s_mem_b [SAMPLE_DEPTH];
   logic [SPW-1:0] s_wr_ptr, s_rd_ptr;
   logic [SPW:0]   s_cnt;
   logic [SPW:0]   s_seen;   // occupancy as seen by the FSM, one cycle behind
   logic           s_push, s_pop;

   // ---------------- weight FIFO ----------------
   logic [2:0]     w_mem_addr [WR_DEPTH];
   logic [7:0]     w_mem_data [WR_DEPTH];
   logic [WPW-1:0] w_wr_ptr, w_rd_ptr, w_rd_nxt;
   logic [WPW:0]   w_cnt;
   logic [WPW:0]   w_seen;
   logic           w_push;
   logic [1:0]     w_pop_n;  // 0, 1 or 2 entries leave per cycle

   assign sample_ready = armed && (s_cnt != S_FULL);
   assign wr_ready     = armed && (w_cnt != W_FULL);
   assign s_push       = sample_valid && sample_ready;
   assign w_push       = wr_valid && wr_ready;
   assign w_rd_nxt     = w_rd_ptr + WPW'(1);

   // The FSM decides from the lagged occupancy, which gives every new entry one
   // registration cycle before the IDLE decision cycle. The lagged view never
   // exceeds the real count while in IDLE, since pops only happen on the edge
   // leaving IDLE and at least one ISSUE cycle follows each of them.
   always_comb begin
      // NOTE: default assignment first so no path leaves pick unassigned,
      // which would otherwise infer a latch.
      pick = PICK_NONE;
      if (w_seen >= (WPW + 1)'(2))
         pick = (w_mem_addr[w_rd_ptr] != w_mem_addr[w_rd_nxt]) ? PICK_DUAL : PICK_SINGLE;
      else if (w_seen == (WPW + 1)'(1))
         pick = PICK_SINGLE;
      else if (s_seen != '0)
         pick = PICK_STEP;
   end

   assign s_pop   = (state == IDLE) && (pick == PICK_STEP);
   assign w_pop_n = (state != IDLE)      ? 2'd0 :
                    (pick == PICK_DUAL)  ? 2'd2 :
                    (pick == PICK_SINGLE)? 2'd1 : 2'd0;

   assign busy = (s_cnt != '0) || (w_cnt != '0) || (state != IDLE);

   // NOTE: FIFO storage is deliberately left out of reset; the counts and
   // pointers alone define which slots hold valid data.
   always_ff @(posedge clk) begin
      if (s_push) begin
         s_mem_a[s_wr_ptr] <= sample_a;
         s_mem_b[s_wr_ptr] <= sample_b;
      end
      if (w_push) begin
         w_mem_addr[w_wr_ptr] <= wr_addr;
         w_mem_data[w_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         armed    <= 1'b0;
         s_wr_ptr <= '0;
         s_rd_ptr <= '0;
         s_cnt    <= '0;
         s_seen   <= '0;
         w_wr_ptr <= '0;
         w_rd_ptr <= '0;
         w_cnt    <= '0;
         w_seen   <= '0;
      end else begin
         armed    <= 1'b1;
         s_wr_ptr <= s_wr_ptr + SPW'(s_push);
         s_rd_ptr <= s_rd_ptr + SPW'(s_pop);
         s_cnt    <= s_cnt + (SPW + 1)'(s_push) - (SPW + 1)'(s_pop);
         s_seen   <= s_cnt;
         w_wr_ptr <= w_wr_ptr + WPW'(w_push);
         w_rd_ptr <= w_rd_ptr + WPW'(w_pop_n);
         w_cnt    <= w_cnt + (WPW + 1)'(w_push) - (WPW + 1)'(w_pop_n);
         w_seen   <= w_cnt;
      end
   end

   // Command FSM. Pulses default low every cycle; the data fields load only on
   // the IDLE->ISSUE edge and only for the command being issued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         gap_cnt           <= '0;
         countSteps        <= 1'b0;
         updateWeight      <= 1'b0;
         dualUpdateWeights <= 1'b0;
         A                 <= '0;
         B                 <= '0;
         Addr1             <= '0;
         Data1             <= '0;
         Addr2             <= '0;
         Data2             <= '0;
      end else begin
         // NOTE: non-blocking throughout, so every read in this block sees the
         // pre-edge value regardless of statement order.
         countSteps        <= 1'b0;
         updateWeight      <= 1'b0;
         dualUpdateWeights <= 1'b0;
         case (state)
            IDLE: begin
               case (pick)
                  PICK_STEP: begin
                     state      <= ISSUE_STEP;
                     countSteps <= 1'b1;
                     A          <= s_mem_a[s_rd_ptr];
                     B          <= s_mem_b[s_rd_ptr];
                  end
                  PICK_SINGLE: begin
                     state        <= ISSUE_SINGLE;
                     updateWeight <= 1'b1;
                     Addr1        <= w_mem_addr[w_rd_ptr];
                     Data1        <= w_mem_data[w_rd_ptr];
                  end
                  PICK_DUAL: begin
                     state             <= ISSUE_DUAL;
                     dualUpdateWeights <= 1'b1;
                     Addr1             <= w_mem_addr[w_rd_ptr];
                     Data1             <= w_mem_data[w_rd_ptr];
                     Addr2             <= w_mem_addr[w_rd_nxt];
                     Data2             <= w_mem_data[w_rd_nxt];
                  end
                  default: ;
               endcase
            end
            ISSUE_STEP, ISSUE_SINGLE, ISSUE_DUAL: begin
               if (CMD_GAP > 0) begin
                  state   <= GAP;
                  gap_cnt <= GAP_LOAD;
               end else begin
                  state <= IDLE;
               end
            end
            GAP: begin
               if (gap_cnt == 4'd0) state <= IDLE;
               else                 gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pedometer_cmd_seq.sv
// Self-checking bench for pedometer_cmd_seq: directed scenarios followed by
// randomized traffic, all compared every cycle against a transaction-level
// reference model (queues of timestamped entries and a next-decision time).
module tb_pedometer_cmd_seq;

   localparam int SD  = 4;
   localparam int WD  = 4;
   localparam int GAP = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sample_valid, wr_valid;
   logic [7:0] sample_a, sample_b, wr_data;
   logic [2:0] wr_addr;
   logic       sample_ready, wr_ready;
   logic       countSteps, updateWeight, dualUpdateWeights, busy;
   logic [7:0] A, B, Data1, Data2;
   logic [2:0] Addr1, Addr2;

   pedometer_cmd_seq #(.SAMPLE_DEPTH(SD), .WR_DEPTH(WD), .CMD_GAP(GAP)) dut (
      .clk(clk), .reset(rst_n),
      .sample_valid(sample_valid), .sample_a(sample_a), .sample_b(sample_b),
      .sample_ready(sample_ready),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .countSteps(countSteps), .updateWeight(updateWeight),
      .dualUpdateWeights(dualUpdateWeights),
      .A(A), .B(B), .Addr1(Addr1), .Data1(Data1), .Addr2(Addr2), .Data2(Data2),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct { logic [7:0] a; logic [7:0] b; int t; } samp_t;
   typedef struct { logic [2:0] addr; logic [7:0] data; int t; } wr_t;

   samp_t      sq[$];
   wr_t        wq[$];
   int         edge_n, next_dec;
   bit         m_armed, s_acc, w_acc;
   logic [2:0] e_pulse;            // {countSteps, updateWeight, dualUpdateWeights}
   logic [7:0] e_a, e_b, e_d1, e_d2;
   logic [2:0] e_a1, e_a2;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      sq.delete();
      wq.delete();
      next_dec = 0;
      m_armed  = 1'b0;
      e_pulse  = '0;
      e_a = '0; e_b = '0; e_d1 = '0; e_d2 = '0; e_a1 = '0; e_a2 = '0;
   endtask

   // One rising edge. An entry accepted at edge t is eligible for a decision
   // at edge t+2; after a command at edge p the next decision is at p+2+GAP.
   task automatic model_edge();
      bit s_ok, w_ok;
      int nw;
      edge_n++;
      s_ok    = m_armed && (sq.size() < SD);
      w_ok    = m_armed && (wq.size() < WD);
      e_pulse = 3'b000;
      if (edge_n >= next_dec) begin
         nw = 0;
         if (wq.size() >= 1 && wq[0].t <= edge_n - 2) nw = 1;
         if (wq.size() >= 2 && wq[1].t <= edge_n - 2) nw = 2;
         if (nw == 2 && wq[0].addr != wq[1].addr) begin
            e_pulse = 3'b001;
            e_a1 = wq[0].addr; e_d1 = wq[0].data;
            e_a2 = wq[1].addr; e_d2 = wq[1].data;
            void'(wq.pop_front());
            void'(wq.pop_front());
         end else if (nw >= 1) begin
            e_pulse = 3'b010;
            e_a1 = wq[0].addr; e_d1 = wq[0].data;
            void'(wq.pop_front());
         end else if (sq.size() >= 1 && sq[0].t <= edge_n - 2) begin
            e_pulse = 3'b100;
            e_a = sq[0].a; e_b = sq[0].b;
            void'(sq.pop_front());
         end
         next_dec = (e_pulse != 3'b000) ? edge_n + 2 + GAP : edge_n + 1;
      end
      s_acc = sample_valid && s_ok;
      w_acc = wr_valid && w_ok;
      if (s_acc) sq.push_back('{a: sample_a, b: sample_b, t: edge_n});
      if (w_acc) wq.push_back('{addr: wr_addr, data: wr_data, t: edge_n});
      m_armed = 1'b1;
   endtask

   task automatic check_all();
      bit e_busy;
      e_busy = (sq.size() != 0) || (wq.size() != 0) || (edge_n < next_dec - 1);
      check("pulse", {countSteps, updateWeight, dualUpdateWeights}, e_pulse);
      check("fields", {A, B, Addr1, Data1, Addr2, Data2}, {e_a, e_b, e_a1, e_d1, e_a2, e_d2});
      check("ready", {sample_ready, wr_ready},
            {m_armed && (sq.size() < SD), m_armed && (wq.size() < WD)});
      check("busy", busy, e_busy);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit sv, input logic [7:0] a, input logic [7:0] b,
                        input bit wv, input logic [2:0] ad, input logic [7:0] d);
      sample_valid = sv; sample_a = a; sample_b = b;
      wr_valid = wv; wr_addr = ad; wr_data = d;
   endtask

   // Called at a falling edge: asserts reset mid-cycle, checks outputs clear
   // at once, holds for a few edges and releases on a falling edge.
   task automatic do_reset(input int hold);
      drive(0, 8'h00, 8'h00, 0, 3'd0, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (hold) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int k;
      int ps, pw;
      rst_n  = 1'b0;
      edge_n = 0;
      s_acc  = 1'b0;
      w_acc  = 1'b0;
      drive(0, 8'h00, 8'h00, 0, 3'd0, 8'h00);
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      cycle();

      // Latency: push at edge t, pulse during the cycle after edge t+2.
      drive(1, 8'h12, 8'h34, 0, 3'd0, 8'h00);
      cycle();
      drive(0, 8'h00, 8'h00, 0, 3'd0, 8'h00);
      cycle();
      check("lat_early", countSteps, 1'b0);
      cycle();
      check("lat_step", {countSteps, updateWeight, dualUpdateWeights}, 3'b100);
      check("lat_ab", {A, B}, 16'h1234);
      repeat (4) cycle();

      // Two writes to different addresses -> one dual command.
      drive(0, 8'h00, 8'h00, 1, 3'd2, 8'h55); cycle();
      drive(0, 8'h00, 8'h00, 1, 3'd5, 8'hAA); cycle();
      drive(0, 8'h00, 8'h00, 0, 3'd0, 8'h00);
      repeat (8) cycle();

      // Two writes to the same address -> two single commands in order.
      drive(0, 8'h00, 8'h00, 1, 3'd3, 8'h01); cycle();
      drive(0, 8'h00, 8'h00, 1, 3'd3, 8'h02); cycle();
      drive(0, 8'h00, 8'h00, 0, 3'd0, 8'h00);
      repeat (10) cycle();

      // Weight write queued with samples lands first; samples keep order.
      drive(1, 8'h21, 8'h22, 1, 3'd6, 8'h77); cycle();
      drive(1, 8'h31, 8'h32, 0, 3'd0, 8'h00); cycle();
      drive(0, 8'h00, 8'h00, 0, 3'd0, 8'h00);
      repeat (12) cycle();

      // Samples held while weights keep the sequencer busy: fills the sample
      // FIFO and wraps its pointers.
      k = 0;
      for (int c = 0; c < 60 && k < 5; c++) begin
         drive(1, 8'(8'hA0 + k), 8'(8'hB0 + k), c < 14, 3'(c % 8), 8'(c));
         cycle();
         if (s_acc) k++;
      end
      check("fill_all_accepted", k, 5);
      drive(0, 8'h00, 8'h00, 0, 3'd0, 8'h00);
      repeat (25) cycle();

      // Reset during GAP with three samples still queued.
      for (int c = 0; c < 4; c++) begin
         drive(1, 8'(8'h40 + c), 8'(8'h50 + c), 0, 3'd0, 8'h00);
         cycle();
      end
      do_reset(2);
      repeat (10) cycle();

      // Randomized traffic in phases of differing load.
      for (int i = 0; i < 3000; i++) begin
         case ((i / 400) % 4)
            0: begin ps = 30; pw = 10; end
            1: begin ps = 80; pw = 50; end
            2: begin ps = 10; pw = 70; end
            default: begin ps = 60; pw = 25; end
         endcase
         drive($urandom_range(99) < ps, 8'($urandom), 8'($urandom),
               $urandom_range(99) < pw,
               ((i / 400) % 2 == 0) ? 3'($urandom_range(1)) : 3'($urandom),
               8'($urandom));
         cycle();
         if (i == 1777) do_reset(1 + int'($urandom_range(2)));
      end
      drive(0, 8'h00, 8'h00, 0, 3'd0, 8'h00);
      repeat (30) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
